// File: rtl/instr_encoder.sv
// Packs MIPS-style fields into 32-bit words and streams them into instruction memory.
// Optional running XOR checksum output enabled by defining ENCODER_CHECKSUM_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rt,
  input  logic [4:0]        rs,
  input  logic [4:0]        rd,
  input  logic [4:0]        shmt,
  input  logic [5:0]        func,
  input  logic [15:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
`ifdef ENCODER_CHECKSUM_EN
  output logic              done,
  output logic [31:0]       checksum
`else
  output logic              done
`endif
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CountOne = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d, count_inc;
  logic            accept;
  logic [31:0]     word;

  assign in_ready  = (state_q == StLoad) && (count_q < DepthCnt);
  // A start while loading restarts the load and drops the coincident beat.
  assign accept    = in_valid && in_ready && !start;
  assign count_inc = count_q + CountOne;
  assign count     = count_q;

  always_comb begin
    word = {opcode, rt, rs, 16'h0000};
    if (opcode == 6'd0) begin
      word[15:0] = {rd, shmt, func};
    end else begin
      word[15:0] = imm;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (accept) begin
      count_d = count_inc;
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      StLoad: begin
        if (start) begin
          count_d = '0;
        end else if (finish || (accept && (count_inc == DepthCnt))) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mem_we  <= accept;
      if (accept) begin
        mem_addr  <= count_q[ADDR_W-1:0];
        mem_wdata <= word;
      end
      busy <= (state_d == StLoad);
      done <= (state_d == StDone);
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  // Folds in the word being written this cycle, so it settles one cycle after the last write.
  always_ff @(posedge clock) begin
    if (reset || start) begin
      checksum <= '0;
    end else if (mem_we) begin
      checksum <= checksum ^ mem_wdata;
    end
  end
`endif

endmodule
